// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the 32x32 register file: clears r1..r(NUM_REGS-1)
// after reset, then arbitrates two writeback requesters round-robin onto
// the single registered A3/WD/WE port.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0_Valid,
    input  logic [ADDR_W-1:0] Req0_Addr,
    input  logic [DATA_W-1:0] Req0_Data,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [ADDR_W-1:0] Req1_Addr,
    input  logic [DATA_W-1:0] Req1_Data,
    output logic              Req1_Ready,
    output logic              WE,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD,
    output logic              Grant_Id,
    output logic              Busy,
    output logic [CNT_W-1:0]  Conflict_Cnt
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   a3_q, a3_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                grant_id_q, grant_id_d;
    logic                busy_q, busy_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;

    logic                run;
    logic                ready0, ready1;
    logic                acc0, acc1;
    logic                win_id;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    // Handshake: favoured port wins a tie; a lone valid port is always ready in RUN.
    always_comb begin
        run      = (state_q == S_RUN);
        ready0   = run && (!Req1_Valid || !rr_ptr_q);
        ready1   = run && (!Req0_Valid ||  rr_ptr_q);
        acc0     = Req0_Valid && ready0;
        acc1     = Req1_Valid && ready1;
        win_id   = acc1;
        win_addr = acc1 ? Req1_Addr : Req0_Addr;
        win_data = acc1 ? Req1_Data : Req0_Data;
    end

    // Next-state: INIT walks the clear address, RUN forwards the accepted request.
    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        we_d           = 1'b0;
        a3_d           = a3_q;
        wd_d           = wd_q;
        grant_id_d     = grant_id_q;
        busy_d         = busy_q;
        rr_ptr_d       = rr_ptr_q;
        conflict_cnt_d = conflict_cnt_q;
        case (state_q)
            S_INIT: begin
                we_d      = 1'b1;
                a3_d      = clr_cnt_q;
                wd_d      = '0;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_REG) begin
                    state_d = S_RUN;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                if (acc0 || acc1) begin
                    rr_ptr_d = ~win_id;
                    // r0 is hardwired zero: the request is consumed but never written.
                    if (win_addr != '0) begin
                        we_d       = 1'b1;
                        a3_d       = win_addr;
                        wd_d       = win_data;
                        grant_id_d = win_id;
                    end
                end
                if (Req0_Valid && Req1_Valid && (conflict_cnt_q != {CNT_W{1'b1}}))
                    conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
            end
        endcase
    end

    // State and registered outputs; reset aborts any clear or write in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q        <= S_INIT;
            clr_cnt_q      <= ADDR_W'(1);
            we_q           <= 1'b0;
            a3_q           <= '0;
            wd_q           <= '0;
            grant_id_q     <= 1'b0;
            busy_q         <= 1'b1;
            rr_ptr_q       <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            we_q           <= we_d;
            a3_q           <= a3_d;
            wd_q           <= wd_d;
            grant_id_q     <= grant_id_d;
            busy_q         <= busy_d;
            rr_ptr_q       <= rr_ptr_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign Req0_Ready   = ready0;
    assign Req1_Ready   = ready1;
    assign WE           = we_q;
    assign A3           = a3_q;
    assign WD           = wd_q;
    assign Grant_Id     = grant_id_q;
    assign Busy         = busy_q;
    assign Conflict_Cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes hand-computed
// expected writes, a negedge monitor pops and compares every WE cycle.
module tb_regfile_write_arbiter;

    logic        Clk;
    logic        Rst_n;
    logic        Req0_Valid;
    logic [4:0]  Req0_Addr;
    logic [31:0] Req0_Data;
    logic        Req0_Ready;
    logic        Req1_Valid;
    logic [4:0]  Req1_Addr;
    logic [31:0] Req1_Data;
    logic        Req1_Ready;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic        Grant_Id;
    logic        Busy;
    logic [15:0] Conflict_Cnt;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        g;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_write_arbiter dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Req0_Valid   (Req0_Valid),
        .Req0_Addr    (Req0_Addr),
        .Req0_Data    (Req0_Data),
        .Req0_Ready   (Req0_Ready),
        .Req1_Valid   (Req1_Valid),
        .Req1_Addr    (Req1_Addr),
        .Req1_Data    (Req1_Data),
        .Req1_Ready   (Req1_Ready),
        .WE           (WE),
        .A3           (A3),
        .WD           (WD),
        .Grant_Id     (Grant_Id),
        .Busy         (Busy),
        .Conflict_Cnt (Conflict_Cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic g);
        exp_t e;
        e.a = a;
        e.d = d;
        e.g = g;
        sb.push_back(e);
    endtask

    // Monitor: every write cycle must match the oldest expected entry.
    always @(negedge Clk) begin
        if (Rst_n && WE === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got A3=%0d WD=%h expected no write at %0t",
                         A3, WD, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_a3", 32'(A3), 32'(e.a));
                chk("wr_wd", WD, e.d);
                chk("wr_gid", 32'(Grant_Id), 32'(e.g));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n      = 1'b0;
        Req0_Valid = 1'b0;
        Req0_Addr  = '0;
        Req0_Data  = '0;
        Req1_Valid = 1'b0;
        Req1_Addr  = '0;
        Req1_Data  = '0;
        repeat (3) tick;

        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_gid", 32'(Grant_Id), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd1);
        chk("rst_cnt", 32'(Conflict_Cnt), 32'd0);
        chk("rst_rdy0", 32'(Req0_Ready), 32'd0);

        // First clear pass, interrupted by reset at A3=12
        for (int i = 1; i <= 12; i++) push(5'(i), 32'd0, 1'b0);
        Rst_n = 1'b1;
        repeat (12) tick;
        chk("init_a3_12", 32'(A3), 32'd12);
        chk("init_busy_12", 32'(Busy), 32'd1);
        @(negedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(WE), 32'd0);
        chk("midrst_a3", 32'(A3), 32'd0);
        chk("midrst_wd", WD, 32'd0);
        chk("midrst_busy", 32'(Busy), 32'd1);
        tick;
        tick;

        // Full clear pass; a request during INIT must be ignored
        Rst_n = 1'b1;
        for (int i = 1; i <= 31; i++) push(5'(i), 32'd0, 1'b0);
        tick;
        chk("restart_a3", 32'(A3), 32'd1);
        repeat (4) tick;
        Req0_Valid = 1'b1;
        Req0_Addr  = 5'd9;
        Req0_Data  = 32'd99;
        #1;
        chk("init_rdy0", 32'(Req0_Ready), 32'd0);
        repeat (4) tick;
        Req0_Valid = 1'b0;
        repeat (21) tick;
        chk("init_busy_30", 32'(Busy), 32'd1);
        chk("init_a3_30", 32'(A3), 32'd30);
        tick;
        chk("init_busy_31", 32'(Busy), 32'd0);
        chk("init_a3_31", 32'(A3), 32'd31);
        tick;
        chk("idle_we", 32'(WE), 32'd0);

        // Port 0 alone
        Req0_Valid = 1'b1;
        Req0_Addr  = 5'd5;
        Req0_Data  = 32'hDEADBEEF;
        #1;
        chk("p0_rdy0", 32'(Req0_Ready), 32'd1);
        chk("p0_rdy1", 32'(Req1_Ready), 32'd0);
        push(5'd5, 32'hDEADBEEF, 1'b0);
        tick;
        Req0_Valid = 1'b0;
        chk("p0_we", 32'(WE), 32'd1);

        // Port 1 alone, returns favour to port 0
        Req1_Valid = 1'b1;
        Req1_Addr  = 5'd6;
        Req1_Data  = 32'h66;
        #1;
        chk("p1_rdy1", 32'(Req1_Ready), 32'd1);
        push(5'd6, 32'h66, 1'b1);
        tick;
        Req1_Valid = 1'b0;

        // Both valid for 4 cycles: p0, p1, p0, p1
        Req0_Valid = 1'b1;
        Req0_Addr  = 5'd3;
        Req0_Data  = 32'h11;
        Req1_Valid = 1'b1;
        Req1_Addr  = 5'd4;
        Req1_Data  = 32'h22;
        push(5'd3, 32'h11, 1'b0);
        push(5'd4, 32'h22, 1'b1);
        push(5'd3, 32'h11, 1'b0);
        push(5'd4, 32'h22, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_rdy0", 32'(Req0_Ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_rdy1", 32'(Req1_Ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick;
        end
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        chk("conflict_4", 32'(Conflict_Cnt), 32'd4);

        // Port 0 write to hand favour to port 1
        Req0_Valid = 1'b1;
        Req0_Addr  = 5'd2;
        Req0_Data  = 32'h2;
        push(5'd2, 32'h2, 1'b0);
        tick;
        Req0_Valid = 1'b0;

        // Same address from both, port 1 favoured: 0xB then 0xA
        Req0_Valid = 1'b1;
        Req0_Addr  = 5'd7;
        Req0_Data  = 32'hA;
        Req1_Valid = 1'b1;
        Req1_Addr  = 5'd7;
        Req1_Data  = 32'hB;
        #1;
        chk("same_rdy1", 32'(Req1_Ready), 32'd1);
        chk("same_rdy0", 32'(Req0_Ready), 32'd0);
        push(5'd7, 32'hB, 1'b1);
        push(5'd7, 32'hA, 1'b0);
        tick;
        #1;
        chk("same_rdy0_2", 32'(Req0_Ready), 32'd1);
        tick;
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;
        chk("conflict_6", 32'(Conflict_Cnt), 32'd6);
        chk("same_final_wd", WD, 32'hA);

        // Port 1 to r0: consumed, no write, outputs held
        Req1_Valid = 1'b1;
        Req1_Addr  = 5'd0;
        Req1_Data  = 32'hFFFF;
        #1;
        chk("r0_rdy1", 32'(Req1_Ready), 32'd1);
        tick;
        Req1_Valid = 1'b0;
        chk("r0_we", 32'(WE), 32'd0);
        chk("r0_a3_hold", 32'(A3), 32'd7);
        chk("r0_wd_hold", WD, 32'hA);
        chk("r0_gid_hold", 32'(Grant_Id), 32'd0);

        // Favour moved to port 0 after the r0 accept
        Req0_Valid = 1'b1;
        Req0_Addr  = 5'd8;
        Req1_Valid = 1'b1;
        Req1_Addr  = 5'd9;
        #1;
        chk("post_r0_rdy0", 32'(Req0_Ready), 32'd1);
        chk("post_r0_rdy1", 32'(Req1_Ready), 32'd0);
        Req0_Valid = 1'b0;
        Req1_Valid = 1'b0;

        repeat (3) tick;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
